// File: rtl/sw_key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_key_pkg
// Description : Shared types and reset constants for the switch/key conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_key_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } deb_state_t;

    // Raw-domain values the synchroniser chains hold in reset
    localparam logic c_sw_sync_rst  = 1'b0;   // switch low
    localparam logic c_key_sync_rst = 1'b1;   // active-low button released

endpackage : sw_key_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : Synchroniser chain plus four-state debounce FSM with strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import sw_key_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit POL_INV         = 1'b0,
    parameter bit RESET_RAW       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    deb_state_t             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_RAW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Polarity fix-up after the last stage so the FSM always sees active-high
    assign sync_lvl = sync_q[SYNC_STAGES-1] ^ POL_INV;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                STABLE_LO: begin
                    if (sync_lvl) begin
                        state_q <= WAIT_HI;
                        cnt_q   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync_lvl) begin
                        state_q <= STABLE_LO;
                    end else if (cnt_q == c_cnt_max) begin
                        state_q <= STABLE_HI;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + c_cnt_one;
                    end
                end
                STABLE_HI: begin
                    if (!sync_lvl) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (sync_lvl) begin
                        state_q <= STABLE_HI;
                    end else if (cnt_q == c_cnt_max) begin
                        state_q <= STABLE_LO;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + c_cnt_one;
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/sw_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : sw_key_conditioner
// Description : Debounced W switch and single-step button feeding the detector.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_key_conditioner
    import sw_key_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    input  logic key_n_raw,
    output logic w_clean,
    output logic w_changed,
    output logic key_level,
    output logic step_pulse
);

    logic sw_rise;
    logic sw_fall;
    logic key_fall;

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .POL_INV         (1'b0),
        .RESET_RAW       (c_sw_sync_rst)
    ) u_sw_chan (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (sw_raw),
        .level_o (w_clean),
        .rise_o  (sw_rise),
        .fall_o  (sw_fall)
    );

    // Button release is deliberately silent: only presses advance the detector
    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .POL_INV         (1'b1),
        .RESET_RAW       (c_key_sync_rst)
    ) u_key_chan (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (key_n_raw),
        .level_o (key_level),
        .rise_o  (step_pulse),
        .fall_o  (key_fall)
    );

    assign w_changed = sw_rise | sw_fall;

    logic unused_key_fall;
    assign unused_key_fall = key_fall;

endmodule : sw_key_conditioner
`default_nettype wire

// File: tb/tb_sw_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_key_conditioner
// Description : Randomised and directed bench against a run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_key_conditioner;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;

    logic clk;
    logic reset;
    logic sw_raw;
    logic key_n_raw;
    logic w_clean;
    logic w_changed;
    logic key_level;
    logic step_pulse;

    sw_key_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .key_n_raw  (key_n_raw),
        .w_clean    (w_clean),
        .w_changed  (w_changed),
        .key_level  (key_level),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: a level flips once DEBOUNCE_CYCLES+1 consecutive delayed samples disagree with it
    bit m_sw_dly[$];
    bit m_key_dly[$];
    bit m_w, m_wchg, m_k, m_step;
    int m_sw_run, m_key_run;

    int tick_no, wchg_cnt, step_cnt, w_edge_tick, k_edge_tick;
    logic prev_w, prev_k;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_sw_dly.delete();
        m_key_dly.delete();
        for (int i = 0; i < SYNC_STAGES; i++) begin
            m_sw_dly.push_back(1'b0);
            m_key_dly.push_back(1'b1);
        end
        m_w = 0; m_wchg = 0; m_k = 0; m_step = 0;
        m_sw_run = 0; m_key_run = 0;
    endtask

    task automatic model_step(input bit sw, input bit key_n);
        bit s, k;
        m_sw_dly.push_back(sw);
        m_key_dly.push_back(key_n);
        s = m_sw_dly.pop_front();
        k = !m_key_dly.pop_front();
        m_wchg = 0;
        m_step = 0;
        if (s != m_w) begin
            m_sw_run++;
            if (m_sw_run == DEBOUNCE_CYCLES + 1) begin
                m_w = s; m_wchg = 1; m_sw_run = 0;
            end
        end else m_sw_run = 0;
        if (k != m_k) begin
            m_key_run++;
            if (m_key_run == DEBOUNCE_CYCLES + 1) begin
                m_k = k; m_step = k; m_key_run = 0;
            end
        end else m_key_run = 0;
    endtask

    task automatic check_outputs(input string pfx);
        check_eq({pfx, "_w_clean"},    32'(w_clean),    32'(m_w));
        check_eq({pfx, "_w_changed"},  32'(w_changed),  32'(m_wchg));
        check_eq({pfx, "_key_level"},  32'(key_level),  32'(m_k));
        check_eq({pfx, "_step_pulse"}, 32'(step_pulse), 32'(m_step));
    endtask

    task automatic clear_stats();
        tick_no = 0; wchg_cnt = 0; step_cnt = 0;
        w_edge_tick = -1; k_edge_tick = -1;
        prev_w = w_clean; prev_k = key_level;
    endtask

    task automatic tick(input bit sw, input bit key_n);
        sw_raw    = sw;
        key_n_raw = key_n;
        @(posedge clk);
        #1;
        model_step(sw, key_n);
        check_outputs("cyc");
        tick_no++;
        if (w_changed)  wchg_cnt++;
        if (step_pulse) step_cnt++;
        if (w_clean !== prev_w)   w_edge_tick = tick_no;
        if (key_level !== prev_k) k_edge_tick = tick_no;
        prev_w = w_clean;
        prev_k = key_level;
    endtask

    task automatic hold(input bit sw, input bit key_n, input int n);
        for (int i = 0; i < n; i++) tick(sw, key_n);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sw_raw = 1'b0; key_n_raw = 1'b1;
        model_reset();
        @(posedge clk); #1;
        apply_reset();

        // Clean switch change
        hold(0, 1, 3);
        clear_stats();
        hold(1, 1, 10);
        check_eq("s1_latency",  32'(w_edge_tick), 32'd7);
        check_eq("s1_wchg_cnt", 32'(wchg_cnt),    32'd1);
        check_eq("s1_step_cnt", 32'(step_cnt),    32'd0);

        // Bounce rejection
        apply_reset();
        clear_stats();
        for (int r = 0; r < 3; r++) begin
            hold(1, 1, 3);
            hold(0, 1, 1);
        end
        check_eq("s2_bounce_wchg", 32'(wchg_cnt), 32'd0);
        clear_stats();
        hold(1, 1, 10);
        check_eq("s2_latency",  32'(w_edge_tick), 32'd7);
        check_eq("s2_wchg_cnt", 32'(wchg_cnt),    32'd1);

        // Button press, hold, release
        apply_reset();
        clear_stats();
        hold(0, 0, 20);
        check_eq("s3_press_lat",  32'(k_edge_tick), 32'd7);
        check_eq("s3_press_step", 32'(step_cnt),    32'd1);
        clear_stats();
        hold(0, 1, 20);
        check_eq("s3_rel_lat",  32'(k_edge_tick), 32'd7);
        check_eq("s3_rel_step", 32'(step_cnt),    32'd0);

        // Reset in the middle of qualification
        apply_reset();
        clear_stats();
        hold(0, 0, 5);
        key_n_raw = 1'b0;
        apply_reset();
        check_eq("s4_abort_step", 32'(step_cnt), 32'd0);
        clear_stats();
        hold(0, 0, 10);
        check_eq("s4_requal_lat",  32'(k_edge_tick), 32'd7);
        check_eq("s4_requal_step", 32'(step_cnt),    32'd1);

        // Concurrent switch and button
        apply_reset();
        clear_stats();
        hold(1, 0, 10);
        check_eq("s5_w_lat",  32'(w_edge_tick), 32'd7);
        check_eq("s5_k_lat",  32'(k_edge_tick), 32'd7);
        check_eq("s5_wchg",   32'(wchg_cnt),    32'd1);
        check_eq("s5_step",   32'(step_cnt),    32'd1);

        // Five single steps with W held low
        apply_reset();
        clear_stats();
        for (int p = 0; p < 5; p++) begin
            hold(0, 0, 8);
            hold(0, 1, 8);
        end
        check_eq("s6_steps",   32'(step_cnt), 32'd5);
        check_eq("s6_wchg",    32'(wchg_cnt), 32'd0);
        check_eq("s6_w_clean", 32'(w_clean),  32'd0);

        // Random segments mixing bounces, accepted changes and occasional resets
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 24) == 0) begin
                apply_reset();
            end else begin
                hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, 9)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sw_key_conditioner
`default_nettype wire

// File: doc/sw_key_conditioner.md
Name: sw_key_conditioner

Overview:
Input-conditioning stage that sits directly upstream of the run-detector FSM (4×0 / 4×1 detector). It synchronises and debounces the raw board switch that supplies W, and the raw active-low push button. The button produces a single-cycle step strobe, so the detector can be single-stepped by hand. Outputs are glitch-free, clk-domain signals that feed the detector's W input and its clock-enable/step path directly.

Parameters:
SYNC_STAGES, 2, flip-flops in each synchroniser chain; legal range ≥2
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); legal range ≥2
CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived, not overridden)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sw_raw  input  1  raw slide switch supplying W, asynchronous to clk
key_n_raw  input  1  raw push button, active-low, asynchronous to clk
w_clean  output  1  debounced W level, to the detector's W input
w_changed  output  1  one-cycle strobe when w_clean toggles
key_level  output  1  debounced button level, active-high (1 = pressed)
step_pulse  output  1  one-cycle strobe on each accepted button press

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - sw synchroniser flops clear to 0.
  - key synchroniser flops set to 1 (button released).
  - Both channels go to STABLE_LO with counter = 0.
  - w_clean = 0, w_changed = 0, key_level = 0, step_pulse = 0.
- Synchroniser: SYNC_STAGES-deep flop chain per input. The key chain output is inverted, so its channel sees an active-high level.
- Debounce channel FSM (one instance per input). States: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: if sync input = 1, go to WAIT_HI and set counter to 0; otherwise hold.
  - WAIT_HI:
    - if sync input = 0, return to STABLE_LO (bounce rejected; level output unchanged).
    - else if counter == DEBOUNCE_CYCLES-1, go to STABLE_HI.
    - else increment counter.
  - STABLE_HI and WAIT_LO are the mirror image of the above.
  - Level output is registered and equals 1 exactly in STABLE_HI and WAIT_LO.
  - Rise strobe: one cycle, on the clock edge where the FSM enters STABLE_HI. Fall strobe: same, on entry to STABLE_LO from WAIT_LO.
- Latency: a clean raw edge held steady appears on the level output exactly SYNC_STAGES + 1 + DEBOUNCE_CYCLES clk edges later. Strobes coincide with that level change.
- Any return to the old level during WAIT restarts qualification from zero. Only accepted changes count; there is no partial credit.
- The counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- w_changed = rise OR fall of the sw channel.
- step_pulse = rise of the key channel only. A held button gives exactly one pulse; release gives none.
- Simultaneous sw and key changes are handled independently with no interaction.
- Reset asserted mid-WAIT aborts qualification immediately. Outputs return to reset values without a strobe.

Decomposition:
- Package sw_key_pkg holds:
  - typedef enum logic [1:0] deb_state_t {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO}
  - the reset constants for sync chains.
- Sub-module debounce_channel: parameters SYNC_STAGES, DEBOUNCE_CYCLES, POL_INV, RESET_RAW; outputs level, rise, fall. It is instantiated twice.
- Top-level sw_key_conditioner is wiring plus the output OR for w_changed.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
1. Clean switch change: reset, release, then sw_raw 0→1 and held → w_clean rises exactly 7 edges after the change, with w_changed high for 1 cycle on that edge. step_pulse stays 0.
2. Bounce rejection: sw_raw pattern 1,1,1,0 repeated ×3, then held at 1 → no output change during bounce. w_clean rises 7 edges after the final 0→1, with a single w_changed pulse.
3. Button press/hold/release: key_n_raw 1→0 held 20 cycles, then 0→1 held → key_level goes 1 seven edges after press with exactly one step_pulse. key_level returns to 0 seven edges after release with no step_pulse.
4. Reset mid-qualification: key_n_raw low for 5 cycles, then assert reset for 1 cycle → all outputs 0 immediately with no step_pulse. After release with key still low, a fresh 7-edge qualification gives one step_pulse.
5. Concurrent events: sw_raw 0→1 and key_n_raw 1→0 on the same edge → w_changed and step_pulse both pulse on the same cycle, 7 edges later.
6. Walk-through with downstream detector: five accepted steps with w_clean held at 0 → detector reaches E and asserts its output.
